inst_encoder: RTL
=================

Name: inst_encoder

Overview:
- Packs decoded instruction fields (opcode class, register indices, funct bits, 32-bit immediate) into a 32-bit RV32I instruction word. It is the inverse of the core's immediate/format decode path.
- Used by the debug/program-loader path to build instruction words written into instruction memory. Also used by the verification environment for round-trip checks against the decoder.
- Two-stage valid/ready pipeline with full backpressure, per-instruction range/alignment checking and a saturating error counter.

Parameters:
- ERR_CNT_W, 16, width of the saturating error counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input fields valid.
- in_ready  out  1  encoder can accept this cycle.
- in_opc  in  5  opcode class, equal to inst[6:2]: Load 00000, Arith_I 00100, AUIPC 00101, Store 01000, Arith_R 01100, LUI 01101, Branch 11000, JALR 11001, JAL 11011.
- in_rd  in  5  destination register.
- in_rs1  in  5  source register 1.
- in_rs2  in  5  source register 2.
- in_funct3  in  3  funct3.
- in_funct7  in  7  funct7 (R-type only).
- in_imm  in  32  signed immediate, byte-offset units for B/J, full value for U.
- out_valid  out  1  encoded word valid.
- out_ready  in  1  downstream accepts.
- out_inst  out  32  encoded instruction.
- out_err  out  1  immediate out of range, misaligned, or unsupported opcode class.
- err_count  out  ERR_CNT_W  saturating count of words delivered with out_err=1.

Behaviour:
- Reset (rst_n low, asynchronous): both stage valids 0, out_valid 0, out_inst 0, out_err 0, err_count 0. in_ready is 1 once reset is released.
- Transfers occur on a rising edge with valid&ready. Input accept happens on in_valid&in_ready; output delivery happens on out_valid&out_ready.
- Stage 1 (S1) registers the inputs. It then computes the format (R/I/S/B/U/J) and the error flag combinationally from the registered fields.
- Stage 2 (S2) registers the packed word and the error flag. S2 drives out_*.
- Latency is 2 cycles from accept to out_valid when there is no stall. Throughput is 1 word per cycle.
- Stage advance: S2 loads when it is empty or delivering this cycle. S1 loads when it is empty or advancing into S2.
- in_ready = !s1_valid || s2_load; this is combinational and contains no path from in_valid.
- Stalls: with out_ready=0, the pipeline holds at most 2 words. in_ready falls once both stages are full. Order is strictly preserved; no drops, no duplicates.
- All formats end in bits[1:0]=2'b11 and bits[6:2]=in_opc.
- Formats:
  - R: funct7, rs2, rs1, funct3, rd.
  - I (Load, Arith_I, JALR): imm[11:0] in [31:20], rs1, funct3, rd.
  - S: imm[11:5] in [31:25], rs2, rs1, funct3, imm[4:0] in [11:7].
  - B: imm[12] in [31], imm[10:5] in [30:25], rs2, rs1, funct3, imm[4:1] in [11:8], imm[11] in [7].
  - U (LUI, AUIPC): imm[31:12] in [31:12], rd.
  - J: imm[20] in [31], imm[10:1] in [30:21], imm[11] in [20], imm[19:12] in [19:12], rd.
- Error conditions, each of which sets err:
  - I/S: imm[31:11] not all equal.
  - B: imm[31:12] not all equal, or imm[0]=1.
  - J: imm[31:20] not all equal, or imm[0]=1.
  - U: imm[11:0]≠0.
  - R: never errors; imm is ignored.
  - Unsupported opcode class: errors and out_inst=0.
- On error the word is still emitted (fields truncated per format) with out_err=1.
- err_count increments once on each delivery with out_err=1 and saturates at all-ones.
- Reset mid-operation discards both stages immediately; counter is cleared.

Test Plan:
- ADDI: opc=00100, rd=1, rs1=0, f3=0, imm=5 -> out_inst=0x00500093, out_err=0, out_valid exactly 2 cycles after accept.
- SW + LUI back-to-back:
  - SW: opc=01000, rs1=1, rs2=2, f3=010, imm=8 -> 0x0020A423.
  - LUI: opc=01101, rd=5, imm=0x12345000 -> 0x123452B7.
  - Both delivered on consecutive cycles.
- JAL: opc=11011, rd=1, imm=0x800 -> 0x001000EF, err=0. Decoding that word through the core immediate path returns 0x00000800.
- Errors:
  - BEQ with imm=3 -> out_err=1, err_count=1.
  - ADDI with imm=4096 -> out_err=1, err_count=2.
  - opc=11111 -> out_inst=0, out_err=1, err_count=3.
- Backpressure: hold out_ready=0 and offer 4 words -> exactly 2 accepted, then in_ready=0. Release out_ready -> all 4 delivered in order, none lost or duplicated.
- Reset: assert rst_n=0 while 2 words are in flight -> out_valid=0 and err_count=0 immediately. After release, in_ready=1 and no stale word appears.

Source files
------------

// File: rtl/inst_encoder.sv
// RV32I instruction word packer: decoded fields in, 32-bit word out.
// Two-stage valid/ready pipeline with range checks and an error counter.
module inst_encoder #(
  parameter int ERR_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4:0]           in_opc,
  input  logic [4:0]           in_rd,
  input  logic [4:0]           in_rs1,
  input  logic [4:0]           in_rs2,
  input  logic [2:0]           in_funct3,
  input  logic [6:0]           in_funct7,
  input  logic [31:0]          in_imm,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_inst,
  output logic                 out_err,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam logic [4:0] OPC_LOAD  = 5'b00000;
  localparam logic [4:0] OPC_ARI   = 5'b00100;
  localparam logic [4:0] OPC_AUIPC = 5'b00101;
  localparam logic [4:0] OPC_STORE = 5'b01000;
  localparam logic [4:0] OPC_ARR   = 5'b01100;
  localparam logic [4:0] OPC_LUI   = 5'b01101;
  localparam logic [4:0] OPC_BR    = 5'b11000;
  localparam logic [4:0] OPC_JALR  = 5'b11001;
  localparam logic [4:0] OPC_JAL   = 5'b11011;

  typedef enum logic [2:0] {
    F_R, F_I, F_S, F_B, F_U, F_J, F_X
  } fmt_e;

  typedef struct packed {
    logic [4:0]  opc;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
  } fld_t;

  fld_t                 s1_q;
  logic                 s1_valid_q;
  logic                 s2_valid_q;
  logic [31:0]          inst_q, inst_d;
  logic                 err_q, err_d;
  logic [ERR_CNT_W-1:0] cnt_q;
  logic                 s1_load, s2_load;
  fmt_e                 fmt;

  assign s2_load  = !s2_valid_q || out_ready;
  assign s1_load  = !s1_valid_q || s2_load;
  assign in_ready = s1_load;

  always_comb begin
    fmt = F_X;
    unique case (1'b1)
      s1_q.opc == OPC_ARR:   fmt = F_R;
      s1_q.opc == OPC_LOAD,
      s1_q.opc == OPC_ARI,
      s1_q.opc == OPC_JALR:  fmt = F_I;
      s1_q.opc == OPC_STORE: fmt = F_S;
      s1_q.opc == OPC_BR:    fmt = F_B;
      s1_q.opc == OPC_LUI,
      s1_q.opc == OPC_AUIPC: fmt = F_U;
      s1_q.opc == OPC_JAL:   fmt = F_J;
      default:               fmt = F_X;
    endcase
  end

  logic [31:0] im;
  logic [6:0]  op;
  logic        ok12, ok13, ok21;

  assign im = s1_q.imm;
  assign op = {s1_q.opc, 2'b11};
  // Immediate fits when all bits above the sign bit match it.
  assign ok12 = (&im[31:11]) || !(|im[31:11]);
  assign ok13 = (&im[31:12]) || !(|im[31:12]);
  assign ok21 = (&im[31:20]) || !(|im[31:20]);

  always_comb begin
    inst_d = '0;
    err_d  = 1'b0;
    unique case (fmt)
      F_R: inst_d = {s1_q.f7, s1_q.rs2, s1_q.rs1,
                     s1_q.f3, s1_q.rd, op};
      F_I: begin
        inst_d = {im[11:0], s1_q.rs1, s1_q.f3,
                  s1_q.rd, op};
        err_d  = !ok12;
      end
      F_S: begin
        inst_d = {im[11:5], s1_q.rs2, s1_q.rs1,
                  s1_q.f3, im[4:0], op};
        err_d  = !ok12;
      end
      F_B: begin
        inst_d = {im[12], im[10:5], s1_q.rs2, s1_q.rs1,
                  s1_q.f3, im[4:1], im[11], op};
        err_d  = !ok13 || im[0];
      end
      F_U: begin
        inst_d = {im[31:12], s1_q.rd, op};
        err_d  = |im[11:0];
      end
      F_J: begin
        inst_d = {im[20], im[10:1], im[11], im[19:12],
                  s1_q.rd, op};
        err_d  = !ok21 || im[0];
      end
      default: begin
        inst_d = '0;
        err_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_q       <= '0;
    end else if (s1_load) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_q <= '{opc: in_opc, rd: in_rd, rs1: in_rs1,
                  rs2: in_rs2, f3: in_funct3,
                  f7: in_funct7, imm: in_imm};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      inst_q     <= '0;
      err_q      <= 1'b0;
    end else if (s2_load) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        inst_q <= inst_d;
        err_q  <= err_d;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (s2_valid_q && out_ready && err_q
                 && !(&cnt_q)) begin
      cnt_q <= cnt_q + ERR_CNT_W'(1);
    end
  end

  assign out_valid = s2_valid_q;
  assign out_inst  = inst_q;
  assign out_err   = err_q;
  assign err_count = cnt_q;

endmodule
